// File: rtl/line_fill_ctrl_pkg.sv
// Shared types for the line fill path: LC-3b word/line types and the fill FSM state encoding.
package line_fill_ctrl_pkg;

  localparam int unsigned LINE_WORDS = 8;

  typedef logic [15:0]                lc3b_word;
  typedef logic [LINE_WORDS*16-1:0]   lc3b_line;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } fill_state_t;

endpackage

// File: rtl/line_fill_ctrl_asm_reg.sv
// Line assembly register: WORDS slots of WIDTH bits, each with its own write enable.
module line_asm_reg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned WORDS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORDS-1:0]       we,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH*WORDS-1:0] line
);

  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
    end else begin
      for (int unsigned k = 0; k < WORDS; k++) begin
        if (we[k]) line[WIDTH*k +: WIDTH] <= wdata;
      end
    end
  end

endmodule

// File: rtl/line_fill_ctrl.sv
// Fills one cache line from a registered-read word array, critical word first, and returns it
// over a valid/ready port.
module line_fill_ctrl
  import line_fill_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = $bits(lc3b_word),
  parameter int unsigned WORDS  = LINE_WORDS,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WIDTH*WORDS-1:0] resp_line,
  output logic                   arr_read,
  output logic [ADDR_W-1:0]      arr_index,
  input  logic [WIDTH-1:0]       arr_data
);

  localparam int unsigned OFF_W = $clog2(WORDS);

  fill_state_t             state, state_nxt;
  logic [ADDR_W-OFF_W-1:0] base;
  logic [OFF_W-1:0]        offset;
  logic [OFF_W-1:0]        issue_cnt;
  logic                    cap;
  logic [OFF_W-1:0]        slot;
  logic [WORDS-1:0]        slot_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      offset    <= '0;
      issue_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            base      <= req_addr[ADDR_W-1:OFF_W];
            offset    <= req_addr[OFF_W-1:0];
            issue_cnt <= '0;
          end
        end
        FILL: begin
          offset    <= offset + 1'b1;
          issue_cnt <= issue_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Data returns one cycle after its strobe, so the slot is always the previously issued offset.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    arr_read   = 1'b0;
    cap        = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = FILL;
      end
      FILL: begin
        arr_read = 1'b1;
        cap      = (issue_cnt != '0);
        if (issue_cnt == OFF_W'(WORDS-1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        cap       = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    slot    = offset - 1'b1;
    slot_we = cap ? (WORDS'(1) << slot) : '0;
  end

  assign arr_index = {base, offset};

  line_asm_reg #(
    .WIDTH (WIDTH),
    .WORDS (WORDS)
  ) u_asm (
    .clk   (clk),
    .rst   (rst),
    .we    (slot_we),
    .wdata (arr_data),
    .line  (resp_line)
  );

endmodule
